trigger_pulse_gen: RTL and testbench

- Multi-channel successor to the single-channel trigger pulse detector.
- Each channel:
  - synchronises an asynchronous trigger input;
  - qualifies an edge over a parametrised number of stable samples (rise, fall or both);
  - emits a programmable-width output pulse, followed by an optional hold-off window.
- Sits between the theremin sensor/comparator inputs and the wishbone trigger register block.
- A shared saturating event counter is exposed for software.

---
 rtl/trigger_pkg.sv | 16 +
 rtl/trigger_chan.sv | 137 +++++++++++++
 rtl/trigger_pulse_gen.sv | 83 ++++++++
 tb/tb_trigger_pulse_gen.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared definitions for the multi-channel trigger pulse generator:
// channel FSM encoding and edge-select mode constants.
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        HOLD  = 2'b10
    } chan_state_t;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

endpackage

// File: rtl/trigger_chan.sv
// One trigger channel: input synchroniser, stable-sample edge qualifier,
// and the IDLE/PULSE/HOLD sequencer with its pulse and hold-off counters.
module trigger_chan
    import trigger_pkg::*;
#(
    parameter int SYNC = 2,
    parameter int QUAL = 2,
    parameter int PW_W = 8
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            i_en,
    input  logic [1:0]      i_mode,
    input  logic [PW_W-1:0] i_pulse_len,
    input  logic [PW_W-1:0] i_holdoff,
    input  logic            i_t_in,
    output logic            o_t_out,
    output logic            o_busy,
    output logic            o_start
);

    logic [SYNC-1:0] r_sync;
    logic [QUAL:0]   r_qual;
    logic            w_rise;
    logic            w_fall;
    logic            w_edge;
    logic            w_evt;

    chan_state_t     r_state;
    chan_state_t     w_state_next;
    logic [PW_W-1:0] r_pcnt;
    logic [PW_W-1:0] w_pcnt_next;
    logic [PW_W-1:0] r_hcnt;
    logic [PW_W-1:0] w_hcnt_next;
    logic            w_start;
    logic            r_t_out;
    logic            r_busy;

    // Multi-flop synchroniser for the asynchronous trigger input.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], i_t_in};
        end
    end

    // Sample history of the synchronised input; runs regardless of en/mode
    // so that re-enabling with a steady input does not look like an edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_qual <= '0;
        end else begin
            r_qual <= {r_qual[QUAL-1:0], r_sync[SYNC-1]};
        end
    end

    // An edge qualifies once QUAL newest samples agree and differ from the one before.
    assign w_rise = (&r_qual[QUAL-1:0]) & ~r_qual[QUAL];
    assign w_fall = ~(|r_qual[QUAL-1:0]) & r_qual[QUAL];

    // Select which qualified edge counts as an event.
    always_comb begin
        w_edge = 1'b0;
        case (i_mode)
            MODE_RISE: w_edge = w_rise;
            MODE_FALL: w_edge = w_fall;
            MODE_BOTH: w_edge = w_rise | w_fall;
            default:   w_edge = 1'b0;
        endcase
    end

    assign w_evt = i_en & w_edge;

    // Next-state and counter logic; dropping en forces IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        w_pcnt_next  = r_pcnt;
        w_hcnt_next  = r_hcnt;
        w_start      = 1'b0;
        if (!i_en) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_evt) begin
                        w_state_next = PULSE;
                        w_start      = 1'b1;
                        w_pcnt_next  = (i_pulse_len == '0) ? PW_W'(1) : i_pulse_len;
                    end
                end
                PULSE: begin
                    if (r_pcnt == PW_W'(1)) begin
                        if (i_holdoff != '0) begin
                            w_state_next = HOLD;
                            w_hcnt_next  = i_holdoff;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_pcnt_next = r_pcnt - PW_W'(1);
                    end
                end
                HOLD: begin
                    if (r_hcnt == PW_W'(1)) begin
                        w_state_next = IDLE;
                    end else begin
                        w_hcnt_next = r_hcnt - PW_W'(1);
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_pcnt  <= '0;
            r_hcnt  <= '0;
            r_t_out <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pcnt  <= w_pcnt_next;
            r_hcnt  <= w_hcnt_next;
            r_t_out <= (w_state_next == PULSE);
            r_busy  <= (w_state_next != IDLE);
        end
    end

    assign o_t_out = r_t_out;
    assign o_busy  = r_busy;
    assign o_start = w_start;

endmodule

// File: rtl/trigger_pulse_gen.sv
// Multi-channel trigger pulse generator: NCH independent channels plus a
// shared saturating count of accepted triggers and an any-pulse flag.
module trigger_pulse_gen
    import trigger_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int SYNC  = 2,
    parameter int QUAL  = 2,
    parameter int PW_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [PW_W-1:0]  pulse_len,
    input  logic [PW_W-1:0]  holdoff,
    input  logic             cnt_clr,
    input  logic [NCH-1:0]   t_in,
    output logic [NCH-1:0]   t_out,
    output logic [NCH-1:0]   busy,
    output logic             t_any,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int POP_W = $clog2(NCH + 1);

    logic [NCH-1:0]   w_t_out;
    logic [NCH-1:0]   w_busy;
    logic [NCH-1:0]   w_start;
    logic [POP_W-1:0] w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] r_evt_cnt;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        trigger_chan #(
            .SYNC (SYNC),
            .QUAL (QUAL),
            .PW_W (PW_W)
        ) u_chan (
            .clk         (clk),
            .clr_n       (clr_n),
            .i_en        (en),
            .i_mode      (mode),
            .i_pulse_len (pulse_len),
            .i_holdoff   (holdoff),
            .i_t_in      (t_in[gi]),
            .o_t_out     (w_t_out[gi]),
            .o_busy      (w_busy[gi]),
            .o_start     (w_start[gi])
        );
    end

    // Number of channels entering PULSE in this cycle.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_pop = w_pop + POP_W'(w_start[i]);
        end
    end

    // One extra bit catches overflow so the counter can stick at all-ones.
    assign w_sum = {1'b0, r_evt_cnt} + (CNT_W + 1)'(w_pop);

    // Saturating event counter; a clear wins over same-cycle increments.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_evt_cnt <= '0;
        end else if (cnt_clr) begin
            r_evt_cnt <= '0;
        end else if (w_sum[CNT_W]) begin
            r_evt_cnt <= '1;
        end else begin
            r_evt_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign t_out   = w_t_out;
    assign busy    = w_busy;
    assign t_any   = |w_t_out;
    assign evt_cnt = r_evt_cnt;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Self-checking bench for trigger_pulse_gen: directed scenarios plus random
// stimulus, compared each cycle against a sample-history/countdown model.
module tb_trigger_pulse_gen;

    localparam int NCH   = 4;
    localparam int SYNC  = 2;
    localparam int QUAL  = 2;
    localparam int PW_W  = 8;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int MAXE  = 90000;

    logic             clk;
    logic             clr_n;
    logic             en;
    logic [1:0]       mode;
    logic [PW_W-1:0]  pulse_len;
    logic [PW_W-1:0]  holdoff;
    logic             cnt_clr;
    logic [NCH-1:0]   t_in;
    logic [NCH-1:0]   t_out;
    logic [NCH-1:0]   busy;
    logic             t_any;
    logic [CNT_W-1:0] evt_cnt;

    int passed = 0;
    int total  = 0;

    // Reference model state: raw input sample per clock edge, and per channel
    // remaining pulse cycles / remaining hold-off cycles.
    int             edge_idx = 0;
    int             base     = 0;
    logic [NCH-1:0] samp [0:MAXE-1];
    int             m_pl [NCH];
    int             m_hl [NCH];
    int             m_cnt;
    logic [NCH-1:0] m_tout;
    logic [NCH-1:0] m_busy;

    trigger_pulse_gen #(
        .NCH   (NCH),
        .SYNC  (SYNC),
        .QUAL  (QUAL),
        .PW_W  (PW_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (en),
        .mode      (mode),
        .pulse_len (pulse_len),
        .holdoff   (holdoff),
        .cnt_clr   (cnt_clr),
        .t_in      (t_in),
        .t_out     (t_out),
        .busy      (busy),
        .t_any     (t_any),
        .evt_cnt   (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input value seen at a given edge; anything sampled before reset release is 0.
    function automatic logic smp(int ch, int idx);
        if (idx < base || idx < 0) return 1'b0;
        return samp[idx][ch];
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_pl[ch] = 0;
            m_hl[ch] = 0;
        end
        m_cnt  = 0;
        base   = edge_idx + 1;
        m_tout = '0;
        m_busy = '0;
    endtask

    // Advance one clock edge and update the model, then settle past the edge.
    task automatic tick();
        int   starts;
        logic all1, all0, last, b, rise, fall, sel;
        @(posedge clk);
        if (edge_idx >= MAXE - 1) begin
            $display("FAIL edge_budget got=%0d limit=%0d", edge_idx, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        edge_idx++;
        samp[edge_idx] = t_in;
        if (!clr_n) begin
            model_reset();
        end else begin
            starts = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                // An edge is judged on the inputs that reached the qualifier
                // SYNC edges late, as of the previous edge.
                all1 = 1'b1;
                all0 = 1'b1;
                for (int j = 0; j < QUAL; j++) begin
                    b    = smp(ch, edge_idx - 1 - SYNC - j);
                    all1 = all1 & b;
                    all0 = all0 & ~b;
                end
                last = smp(ch, edge_idx - 1 - SYNC - QUAL);
                rise = all1 & ~last;
                fall = all0 & last;
                case (mode)
                    2'b00:   sel = rise;
                    2'b01:   sel = fall;
                    2'b10:   sel = rise | fall;
                    default: sel = 1'b0;
                endcase
                if (!en) begin
                    m_pl[ch] = 0;
                    m_hl[ch] = 0;
                end else if (m_pl[ch] > 0) begin
                    m_pl[ch]--;
                    if (m_pl[ch] == 0) m_hl[ch] = int'(holdoff);
                end else if (m_hl[ch] > 0) begin
                    m_hl[ch]--;
                end else if (sel) begin
                    m_pl[ch] = (pulse_len == '0) ? 1 : int'(pulse_len);
                    starts++;
                end
            end
            if (cnt_clr) m_cnt = 0;
            else m_cnt = (m_cnt + starts > CMAX) ? CMAX : m_cnt + starts;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            m_tout[ch] = (m_pl[ch] > 0);
            m_busy[ch] = (m_pl[ch] > 0) || (m_hl[ch] > 0);
        end
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; en = 1'b0; mode = 2'b00; pulse_len = '0; holdoff = '0;
        cnt_clr = 1'b0; t_in = '0;
        model_reset();
        tick(); tick();
        if ({t_out, busy, t_any, evt_cnt} !== '0) begin
            $display("FAIL reset_held got=%h want=0", {t_out, busy, t_any, evt_cnt});
        end else passed++;
        total++;
        clr_n = 1'b1;
        repeat (4) begin
            tick();
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL reset_idle edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        $display("test_reset done edge=%0d", edge_idx);
    endtask

    task automatic test_latency();
        int cnt0;
        en = 1'b1; mode = 2'b00; pulse_len = 8'd3; holdoff = '0; t_in = '0;
        repeat (6) tick();
        cnt0 = m_cnt;
        t_in[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (t_out[0] !== ((e >= 5) && (e <= 7))) begin
                $display("FAIL latency_t_out0 edge_after_rise=%0d got=%b want=%b", e, t_out[0], (e >= 5) && (e <= 7));
            end else passed++;
            total++;
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL latency edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        if (evt_cnt !== CNT_W'(cnt0 + 1)) begin
            $display("FAIL latency_count got=%h want=%h", evt_cnt, CNT_W'(cnt0 + 1));
        end else passed++;
        total++;
        t_in = '0;
        repeat (8) tick();
        $display("test_latency done edge=%0d", edge_idx);
    endtask

    task automatic test_glitch();
        int   cnt0;
        logic seen;
        cnt0 = m_cnt;
        seen = 1'b0;
        t_in[1] = 1'b1;
        tick();
        t_in[1] = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | t_out[1];
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL glitch edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        if (seen !== 1'b0 || evt_cnt !== CNT_W'(cnt0)) begin
            $display("FAIL glitch_ignored got pulse=%b cnt=%h want pulse=0 cnt=%h", seen, evt_cnt, CNT_W'(cnt0));
        end else passed++;
        total++;
        $display("test_glitch done edge=%0d", edge_idx);
    endtask

    task automatic test_both_holdoff();
        logic prev;
        mode = 2'b10; pulse_len = '0; holdoff = 8'd4;
        prev = 1'b0;
        for (int c = 0; c < 45; c++) begin
            if (c % 3 == 0) t_in[2] = ~t_in[2];
            tick();
            if (prev && t_out[2]) begin
                $display("FAIL both_one_cycle edge=%0d got=two-cycle pulse want=single", edge_idx);
            end else passed++;
            total++;
            prev = t_out[2];
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL both_holdoff edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        mode = 2'b00; holdoff = '0; t_in = '0;
        repeat (10) tick();
        $display("test_both_holdoff done edge=%0d", edge_idx);
    endtask

    task automatic test_simultaneous();
        int cnt0;
        mode = 2'b00; pulse_len = 8'd2; holdoff = '0;
        cnt0 = m_cnt;
        t_in = '1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5 && t_out !== 4'hF) begin
                $display("FAIL simul_all got=%h want=f", t_out);
            end else if (e == 5) passed++;
            if (e == 5) total++;
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL simul edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        if (evt_cnt !== CNT_W'(cnt0 + 4)) begin
            $display("FAIL simul_count got=%h want=%h", evt_cnt, CNT_W'(cnt0 + 4));
        end else passed++;
        total++;
        t_in = '0;
        repeat (8) tick();
        $display("test_simultaneous done edge=%0d", edge_idx);
    endtask

    task automatic test_saturate();
        int n;
        mode = 2'b10; pulse_len = 8'd1; holdoff = '0;
        n = 0;
        while (m_cnt < 'hFFF0 && n < 30000) begin
            t_in = ~t_in;
            tick(); tick();
            n++;
            if (n % 1024 == 0) begin
                if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                    $display("FAIL sat_fill edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
                end else passed++;
                total++;
            end
        end
        if (n >= 30000) begin
            $display("FAIL sat_fill_budget got=%0d want<%0d", n, 30000);
        end else passed++;
        total++;
        mode = 2'b00;
        t_in = '0;
        repeat (8) tick();
        repeat (5) begin
            t_in = '1;
            repeat (6) begin
                tick();
                if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                    $display("FAIL sat_burst edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
                end else passed++;
                total++;
            end
            t_in = '0;
            repeat (4) tick();
            $display("sat burst edge=%0d evt_cnt=%h", edge_idx, evt_cnt);
        end
        if (evt_cnt !== 16'hFFFF) begin
            $display("FAIL sat_final got=%h want=ffff", evt_cnt);
        end else passed++;
        total++;
        $display("test_saturate done edge=%0d", edge_idx);
    endtask

    task automatic test_cnt_clr();
        mode = 2'b00; pulse_len = 8'd1;
        t_in = '1;
        repeat (4) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        if (evt_cnt !== '0 || t_out !== 4'hF) begin
            $display("FAIL clr_priority got cnt=%h t_out=%h want cnt=0 t_out=f", evt_cnt, t_out);
        end else passed++;
        total++;
        repeat (4) begin
            tick();
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL clr edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        t_in = '0;
        repeat (8) tick();
        $display("test_cnt_clr done edge=%0d", edge_idx);
    endtask

    task automatic test_enable();
        logic seen;
        mode = 2'b00; pulse_len = 8'd10; holdoff = '0;
        t_in[3] = 1'b1;
        repeat (7) tick();
        en = 1'b0;
        tick();
        if (t_out !== '0 || busy !== '0) begin
            $display("FAIL en_truncate got t_out=%h busy=%h want 0 0", t_out, busy);
        end else passed++;
        total++;
        en = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | t_out[3];
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL en_resume edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        if (seen !== 1'b0) begin
            $display("FAIL en_no_refire got=%b want=0", seen);
        end else passed++;
        total++;
        t_in = '0;
        repeat (8) tick();
        $display("test_enable done edge=%0d", edge_idx);
    endtask

    task automatic test_random();
        int hold [NCH];
        for (int ch = 0; ch < NCH; ch++) hold[ch] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (hold[ch] == 0) begin
                    t_in[ch] = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(0, 4);
                end else hold[ch]--;
            end
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pulse_len = PW_W'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) holdoff = PW_W'($urandom_range(0, 4));
            if (en && $urandom_range(0, 29) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            cnt_clr = ($urandom_range(0, 49) == 0);
            tick();
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL random edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        en = 1'b1; cnt_clr = 1'b0; mode = 2'b00; holdoff = '0; t_in = '0;
        repeat (12) tick();
        $display("test_random done edge=%0d evt_cnt=%h", edge_idx, evt_cnt);
    endtask

    task automatic test_async_reset();
        mode = 2'b00; pulse_len = 8'd10; holdoff = '0;
        t_in[0] = 1'b1;
        repeat (7) tick();
        if (t_out[0] !== 1'b1) begin
            $display("FAIL areset_pre got=%b want=1", t_out[0]);
        end else passed++;
        total++;
        #2;
        clr_n = 1'b0;
        model_reset();
        #1;
        if ({t_out, busy, t_any, evt_cnt} !== '0) begin
            $display("FAIL areset_immediate got=%h want=0", {t_out, busy, t_any, evt_cnt});
        end else passed++;
        total++;
        t_in = '0;
        tick(); tick();
        clr_n = 1'b1;
        repeat (4) tick();
        t_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (t_out[0] !== (e >= 5)) begin
                $display("FAIL areset_latency edge_after_rise=%0d got=%b want=%b", e, t_out[0], e >= 5);
            end else passed++;
            total++;
            if ({t_out, busy, t_any, evt_cnt} !== {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)}) begin
                $display("FAIL areset edge=%0d got=%h want=%h", edge_idx, {t_out, busy, t_any, evt_cnt}, {m_tout, m_busy, |m_tout, CNT_W'(m_cnt)});
            end else passed++;
            total++;
        end
        $display("test_async_reset done edge=%0d", edge_idx);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_both_holdoff();
        test_simultaneous();
        test_saturate();
        test_cnt_clr();
        test_enable();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
